sirv_gnrl_skidbuf: RTL and testbench

Two-entry valid/ready skid buffer placed directly in front of load-enabled data registers in the pipeline. It accepts one beat per cycle from the producer and holds it in a main register that drives the consumer. A second skid register absorbs one extra beat when the consumer stalls. Every output, including `i_rdy`, is registered, so there is no combinational path from `o_rdy` to `i_rdy`.

---
 rtl/sirv_gnrl_skidbuf_pkg.sv | 27 ++
 rtl/sirv_gnrl_skidbuf_dff.sv | 36 +++
 rtl/sirv_gnrl_skidbuf.sv | 95 +++++++++
 tb/tb_sirv_gnrl_skidbuf.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sirv_gnrl_skidbuf_pkg.sv
// Purpose: shared state encoding and decode helpers for the two-entry skid buffer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sirv_gnrl_skidbuf_pkg;

  localparam int         SKID_STW   = 2;
  localparam logic [1:0] SKID_EMPTY = 2'b00;
  localparam logic [1:0] SKID_BUSY  = 2'b01;
  localparam logic [1:0] SKID_FULL  = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = SKID_EMPTY,
    ST_BUSY  = SKID_BUSY,
    ST_FULL  = SKID_FULL
  } skid_st_e;

  // Consumer side sees a beat in BUSY and FULL only; 2'b11 reads as empty.
  function automatic logic skid_o_vld(input logic [1:0] st);
    return (st == SKID_BUSY) || (st == SKID_FULL);
  endfunction

  // Producer side is blocked only when both entries are occupied.
  function automatic logic skid_i_rdy(input logic [1:0] st);
    return (st != SKID_FULL);
  endfunction

endpackage

// File: rtl/sirv_gnrl_skidbuf_dff.sv
// Purpose: load-enable flop cells; sirv_gnrl_dffl (no reset) and sirv_gnrl_dfflr (async active-low reset).
// Latency: one clock from lden/dnxt to qout.
// Backpressure: none; the cell loads whenever lden is high.
// Ports: lden load enable, dnxt next value, qout registered value, clk clock, rst_n reset (dfflr only).
module sirv_gnrl_dffl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (lden) qout <= dnxt;
  end

endmodule

module sirv_gnrl_dfflr #(
  parameter int          DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    qout <= RST_VAL;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/sirv_gnrl_skidbuf.sv
// Purpose: two-entry valid/ready skid buffer; main register drives the consumer, skid absorbs one stalled beat.
// Latency: one clock from input handshake to o_vld/o_dat; one beat per cycle sustained.
// Backpressure: i_rdy is a registered state decode, drops one cycle after the first stall; no o_rdy->i_rdy path.
// Ports: clk, rst_n; producer i_vld/i_rdy/i_dat; consumer o_vld/o_rdy/o_dat (o_dat is the main register).
module sirv_gnrl_skidbuf
  import sirv_gnrl_skidbuf_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);

  logic [SKID_STW-1:0] state_r;
  logic [SKID_STW-1:0] state_nxt;
  logic                main_ena;
  logic                skid_ena;
  logic [DW-1:0]       main_nxt;
  logic [DW-1:0]       skid_r;

  always_comb begin
    state_nxt = state_r;
    main_ena  = 1'b0;
    skid_ena  = 1'b0;
    main_nxt  = i_dat;
    case (state_r)
      SKID_EMPTY: begin
        if (i_vld) begin
          state_nxt = SKID_BUSY;
          main_ena  = 1'b1;
        end
      end
      SKID_BUSY: begin
        if (i_vld && o_rdy) begin
          // Main beat leaves while the new one replaces it: occupancy unchanged.
          main_ena = 1'b1;
        end else if (i_vld) begin
          // i_rdy was still high this cycle, so the in-flight beat must land in skid.
          state_nxt = SKID_FULL;
          skid_ena  = 1'b1;
        end else if (o_rdy) begin
          state_nxt = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (o_rdy) begin
          // Skid beat is always the younger one; promote it to keep arrival order.
          state_nxt = SKID_BUSY;
          main_ena  = 1'b1;
          main_nxt  = skid_r;
        end
      end
      default: state_nxt = SKID_EMPTY;
    endcase
  end

  sirv_gnrl_dfflr #(
    .DW      (SKID_STW),
    .RST_VAL (SKID_EMPTY)
  ) u_state (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (1'b1),
    .dnxt  (state_nxt),
    .qout  (state_r)
  );

  sirv_gnrl_dffl #(
    .DW (DW)
  ) u_main (
    .clk  (clk),
    .lden (main_ena),
    .dnxt (main_nxt),
    .qout (o_dat)
  );

  sirv_gnrl_dffl #(
    .DW (DW)
  ) u_skid (
    .clk  (clk),
    .lden (skid_ena),
    .dnxt (i_dat),
    .qout (skid_r)
  );

  assign o_vld = skid_o_vld(state_r);
  assign i_rdy = skid_i_rdy(state_r);

endmodule

// File: tb/tb_sirv_gnrl_skidbuf.sv
// Purpose: self-checking bench for sirv_gnrl_skidbuf; directed table plus queue-referenced sequences.
// Latency: n/a.
// Backpressure: producer holds i_vld/i_dat stable while the reference says the buffer is full.
module tb_sirv_gnrl_skidbuf;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;

  int n_chk;
  int n_fail;

  logic [DW-1:0] q[$];

  sirv_gnrl_skidbuf #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        ordy;
    logic        e_ovld;
    logic        e_irdy;
    logic [31:0] e_odat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle against the reference queue: occupancy = q.size(), o_vld = size>0,
  // i_rdy = size<2, o_dat = oldest beat.
  task automatic cyc(input logic vld, input logic [31:0] dat, input logic ordy, output logic acc);
    logic m_in;
    logic m_out;
    m_in  = vld && (q.size() < 2);
    m_out = ordy && (q.size() > 0);
    i_vld = vld;
    i_dat = dat;
    o_rdy = ordy;
    @(posedge clk);
    #1;
    if (m_out) void'(q.pop_front());
    if (m_in) q.push_back(dat);
    acc = m_in;
    chk("o_vld", {31'b0, o_vld}, {31'b0, q.size() > 0});
    chk("i_rdy", {31'b0, i_rdy}, {31'b0, q.size() < 2});
    if (q.size() > 0) chk("o_dat", o_dat, q[0]);
  endtask

  initial begin
    logic        acc;
    logic [31:0] nd;
    logic        hold;
    logic        rv;
    int          stall_cnt;

    n_chk  = 0;
    n_fail = 0;
    i_vld  = 1'b0;
    i_dat  = '0;
    o_rdy  = 1'b0;
    rst_n  = 1'b0;

    tbl[0]  = '{1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11};
    tbl[1]  = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22};
    tbl[2]  = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 32'h22};
    tbl[3]  = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'h22};
    tbl[4]  = '{1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h33};
    tbl[5]  = '{1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h44};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h55};
    tbl[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h55};
    tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_vld", {31'b0, o_vld}, 32'd0);
    chk("rst_i_rdy", {31'b0, i_rdy}, 32'd1);
    rst_n = 1'b1;

    // Directed table
    for (int k = 0; k < 11; k++) begin
      i_vld = tbl[k].vld;
      i_dat = tbl[k].dat;
      o_rdy = tbl[k].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_o_vld", k), {31'b0, o_vld}, {31'b0, tbl[k].e_ovld});
      chk($sformatf("tbl%0d_i_rdy", k), {31'b0, i_rdy}, {31'b0, tbl[k].e_irdy});
      if (tbl[k].e_ovld) chk($sformatf("tbl%0d_o_dat", k), o_dat, tbl[k].e_odat);
    end
    q.delete();

    // Streaming: 16 beats back-to-back, no bubbles
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, k, 1'b1, acc);
      chk("stream_acc", {31'b0, acc}, 32'd1);
      chk("stream_dat", o_dat, k);
    end
    cyc(1'b0, 32'h0, 1'b1, acc);

    // Single stall mid-burst
    nd = 32'h100;
    stall_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, nd, (c != 3), acc);
      if (acc) nd++;
      if (!i_rdy) stall_cnt++;
    end
    chk("single_stall_irdy_low_cycles", stall_cnt, 32'd1);
    while (q.size() > 0) cyc(1'b0, 32'h0, 1'b1, acc);
    chk("single_stall_last", o_vld, 32'd0);

    // Long stall: 10 cycles o_rdy=0 with i_vld=1
    nd = 32'h200;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, nd, 1'b0, acc);
      if (acc) nd++;
    end
    chk("long_stall_stored", nd - 32'h200, 32'd2);
    chk("long_stall_irdy", {31'b0, i_rdy}, 32'd0);
    cyc(1'b0, 32'h0, 1'b1, acc);
    chk("long_drain0", o_dat, 32'h201);
    cyc(1'b0, 32'h0, 1'b1, acc);
    chk("long_drain_empty", {31'b0, o_vld}, 32'd0);

    // Reset mid-stream while FULL
    cyc(1'b1, 32'hAAAA0001, 1'b0, acc);
    cyc(1'b1, 32'hAAAA0002, 1'b0, acc);
    chk("pre_rst_full", {31'b0, i_rdy}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_o_vld", {31'b0, o_vld}, 32'd0);
    chk("midrst_i_rdy", {31'b0, i_rdy}, 32'd1);
    #2 rst_n = 1'b1;
    q.delete();
    i_vld = 1'b0;
    for (int c = 0; c < 3; c++) cyc(1'b0, 32'h0, 1'b1, acc);
    cyc(1'b1, 32'h0000BEEF, 1'b0, acc);
    cyc(1'b0, 32'h0, 1'b1, acc);
    cyc(1'b0, 32'h0, 1'b1, acc);

    // Random traffic against the reference queue
    hold = 1'b0;
    nd   = $urandom;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        rv = 1'($urandom_range(0, 1));
        nd = $urandom;
      end else begin
        rv = 1'b1;
      end
      cyc(rv, nd, 1'($urandom_range(0, 1)), acc);
      hold = rv && !acc;
    end
    while (q.size() > 0) cyc(1'b0, 32'h0, 1'b1, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
